ram_access_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the 256x32 RAM array, which is built from ram16x4 chips. It accepts independent read/write requests from requester A and requester B and grants one at a time. It drives the RAM's active-low chip select, read/write, address and write-data lines through a fixed setup / strobe / hold sequence. It returns read data and a one-cycle acknowledge to the granted requester.

---
 rtl/ram_access_arbiter_if.sv | 49 ++++
 rtl/ram_access_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_access_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_arbiter_if.sv
// ram_access_arbiter_if
//   Bundles the two requester ports (A and B) and the RAM-side bus of the
//   ram_access_arbiter into one interface.
//   Requester ports : x_req, x_rw, x_adrs, x_wdata -> arbiter
//                     x_ack, x_rdata               <- arbiter
//   RAM bus         : ram_cs, ram_rw, ram_adrs, ram_data_in <- arbiter
//                     ram_data_out                         -> arbiter
//   Modport slave is the arbiter's view; modport master is the view of the
//   surrounding system (requesters plus RAM array).
interface ram_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic              a_rw;
  logic [ADDR_W-1:0] a_adrs;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_rw;
  logic [ADDR_W-1:0] b_adrs;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_cs;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_adrs;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  a_req, a_rw, a_adrs, a_wdata,
    input  b_req, b_rw, b_adrs, b_wdata,
    input  ram_data_out,
    output a_ack, a_rdata, b_ack, b_rdata,
    output ram_cs, ram_rw, ram_adrs, ram_data_in
  );

  modport master (
    output a_req, a_rw, a_adrs, a_wdata,
    output b_req, b_rw, b_adrs, b_wdata,
    output ram_data_out,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  ram_cs, ram_rw, ram_adrs, ram_data_in
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//   Round-robin arbiter and access sequencer for the 256x32 RAM array built
//   from ram16x4 chips. Grants one of two requesters at a time and runs a
//   fixed IDLE -> SETUP -> STROBE -> HOLD sequence on the RAM bus, returning
//   registered read data and a one-cycle acknowledge to the winner.
//   Parameters : ADDR_W, DATA_W, WAIT_CYCLES (strobe length, must be >= 1)
//   Ports      : clk   - single clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - requester A/B ports and RAM bus (slave modport)
module ram_access_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  ram_access_arbiter_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              grant_b;
  logic              last_grant_b;
  logic              pick_b;

  logic              ram_cs_q;
  logic              ram_rw_q;
  logic [ADDR_W-1:0] ram_adrs_q;
  logic [DATA_W-1:0] ram_data_in_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Winner selection for the IDLE cycle: a lone requester wins outright;
  // on a tie the requester that was not served last takes the grant.
  always_comb begin
    pick_b = 1'b0;
    if (bus.b_req && !bus.a_req) begin
      pick_b = 1'b1;
    end else if (bus.a_req && bus.b_req) begin
      pick_b = !last_grant_b;
    end
  end

  // Access sequencer. All RAM-side and requester-side outputs are registered
  // here; the RAM bus fields are only loaded on the edge leaving IDLE, so
  // they are stable across SETUP, the whole strobe, and HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      grant_b       <= 1'b0;
      last_grant_b  <= 1'b1;
      ram_cs_q      <= 1'b1;
      ram_rw_q      <= 1'b0;
      ram_adrs_q    <= '0;
      ram_data_in_q <= '0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            grant_b       <= pick_b;
            ram_rw_q      <= pick_b ? bus.b_rw    : bus.a_rw;
            ram_adrs_q    <= pick_b ? bus.b_adrs  : bus.a_adrs;
            ram_data_in_q <= pick_b ? bus.b_wdata : bus.a_wdata;
            state         <= SETUP;
          end
        end

        // Chip select drops on the edge leaving SETUP; the counter counts
        // down the remaining strobe cycles after the first one.
        SETUP: begin
          wait_cnt <= CNT_LOAD;
          ram_cs_q <= 1'b0;
          state    <= STROBE;
        end

        // The final strobe edge samples the RAM's read data directly into
        // the winner's rdata register and raises its acknowledge.
        STROBE: begin
          if (wait_cnt == '0) begin
            ram_cs_q <= 1'b1;
            state    <= HOLD;
            if (grant_b) begin
              b_ack_q <= 1'b1;
              if (!ram_rw_q) begin
                b_rdata_q <= bus.ram_data_out;
              end
            end else begin
              a_ack_q <= 1'b1;
              if (!ram_rw_q) begin
                a_rdata_q <= bus.ram_data_out;
              end
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        HOLD: begin
          a_ack_q      <= 1'b0;
          b_ack_q      <= 1'b0;
          last_grant_b <= grant_b;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_cs      = ram_cs_q;
  assign bus.ram_rw      = ram_rw_q;
  assign bus.ram_adrs    = ram_adrs_q;
  assign bus.ram_data_in = ram_data_in_q;
  assign bus.a_ack       = a_ack_q;
  assign bus.b_ack       = b_ack_q;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
//   Bench for ram_access_arbiter. Two instances: one with WAIT_CYCLES=1
//   (main sequence) and one with WAIT_CYCLES=3 (long strobe). Each instance
//   sits on a behavioural 256x32 RAM. Expected values come from a
//   transaction-level model: a shadow memory, per-port expected rdata, and
//   the round-robin rule "on a tie, the port not served last wins".
module tb_ram_access_arbiter;

  localparam int W1 = 1;
  localparam int W3 = 3;

  logic clk;
  logic rst_n;
  bit   ram_fill;

  int vectors;
  int miscompares;

  ram_access_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();
  ram_access_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus3 ();

  ram_access_arbiter #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ram_access_arbiter #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // Behavioural RAM arrays: written on a clock edge while selected in write
  // mode, read combinationally. Preloaded with random contents at start.
  logic [31:0] init_mem  [256];
  logic [31:0] init_mem3 [256];
  logic [31:0] ram_mem   [256];
  logic [31:0] ram_mem3  [256];

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_mem[i];
    end else if (!bus.ram_cs && bus.ram_rw) begin
      ram_mem[bus.ram_adrs] <= bus.ram_data_in;
    end
  end

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 256; i++) ram_mem3[i] <= init_mem3[i];
    end else if (!bus3.ram_cs && bus3.ram_rw) begin
      ram_mem3[bus3.ram_adrs] <= bus3.ram_data_in;
    end
  end

  assign bus.ram_data_out  = ram_mem[bus.ram_adrs];
  assign bus3.ram_data_out = ram_mem3[bus3.ram_adrs];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] exp_mem [256];
  logic [31:0] exp_rdata_a;
  logic [31:0] exp_rdata_b;
  bit          model_last_b;
  logic [7:0]  last_adrs;
  bit          seen_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit port_b, input logic rw,
                               input logic [7:0] adrs, input logic [31:0] wdata);
    if (port_b) begin
      bus.b_req = 1'b1; bus.b_rw = rw; bus.b_adrs = adrs; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_rw = rw; bus.a_adrs = adrs; bus.a_wdata = wdata;
    end
  endtask

  // An IDLE cycle with nothing requested: bus idle, RAM fields unchanged.
  task automatic idleCycle();
    tick();
    checkOutput("idle_cs", bus.ram_cs, 1);
    checkOutput("idle_acks", {bus.a_ack, bus.b_ack}, 0);
    checkOutput("idle_adrs_hold", bus.ram_adrs, last_adrs);
  endtask

  // Runs one complete access. Called during the IDLE cycle in which at least
  // one request is high; returns during the following IDLE cycle.
  task automatic serveOne(input bit keep_req);
    bit          win_b;
    logic        rw;
    logic [7:0]  ad;
    logic [31:0] wd;
    if (bus.a_req && bus.b_req) win_b = !model_last_b;
    else                        win_b = bus.b_req;
    rw = win_b ? bus.b_rw    : bus.a_rw;
    ad = win_b ? bus.b_adrs  : bus.a_adrs;
    wd = win_b ? bus.b_wdata : bus.a_wdata;

    tick();
    checkOutput("setup_cs", bus.ram_cs, 1);
    checkOutput("setup_rw", bus.ram_rw, rw);
    checkOutput("setup_adrs", bus.ram_adrs, ad);
    checkOutput("setup_wdata", bus.ram_data_in, wd);
    checkOutput("setup_acks", {bus.a_ack, bus.b_ack}, 0);

    for (int c = 0; c < W1; c++) begin
      tick();
      checkOutput("strobe_cs", bus.ram_cs, 0);
      checkOutput("strobe_acks", {bus.a_ack, bus.b_ack}, 0);
      checkOutput("strobe_adrs", bus.ram_adrs, ad);
      checkOutput("strobe_rw", bus.ram_rw, rw);
    end

    tick();
    if (rw) exp_mem[ad] = wd;
    else if (win_b) exp_rdata_b = exp_mem[ad];
    else exp_rdata_a = exp_mem[ad];
    model_last_b = win_b;
    last_adrs    = ad;
    seen_b       = bus.b_ack;
    checkOutput("hold_cs", bus.ram_cs, 1);
    checkOutput("hold_acks", {bus.a_ack, bus.b_ack}, win_b ? 32'd1 : 32'd2);
    checkOutput("hold_adrs", bus.ram_adrs, ad);
    checkOutput("hold_wdata", bus.ram_data_in, wd);
    checkOutput("a_rdata", bus.a_rdata, exp_rdata_a);
    checkOutput("b_rdata", bus.b_rdata, exp_rdata_b);

    if (!keep_req) begin
      if (win_b) bus.b_req = 1'b0;
      else       bus.a_req = 1'b0;
    end

    tick();
    checkOutput("post_cs", bus.ram_cs, 1);
    checkOutput("post_acks", {bus.a_ack, bus.b_ack}, 0);
  endtask

  logic [7:0] pool [4];

  initial begin
    vectors      = 0;
    miscompares  = 0;
    pool[0] = 8'h00; pool[1] = 8'h3C; pool[2] = 8'h10; pool[3] = 8'hFF;
    for (int i = 0; i < 256; i++) begin
      init_mem[i]  = $urandom;
      init_mem3[i] = $urandom;
      exp_mem[i]   = init_mem[i];
    end
    exp_rdata_a  = '0;
    exp_rdata_b  = '0;
    model_last_b = 1'b1;
    last_adrs    = '0;
    ram_fill     = 1'b1;
    rst_n        = 1'b0;
    bus3.a_req = 1'b0; bus3.a_rw = 1'b0; bus3.a_adrs = '0; bus3.a_wdata = '0;
    bus3.b_req = 1'b0; bus3.b_rw = 1'b0; bus3.b_adrs = '0; bus3.b_wdata = '0;

    // Reset with both requesting: A writes DEADBEEF to 3C, B reads 3C.
    applyStimulus(0, 1'b1, 8'h3C, 32'hDEADBEEF);
    applyStimulus(1, 1'b0, 8'h3C, 32'h0);
    for (int r = 0; r < 2; r++) begin
      tick();
      ram_fill = 1'b0;
      checkOutput("rst_cs", bus.ram_cs, 1);
      checkOutput("rst_acks", {bus.a_ack, bus.b_ack}, 0);
      checkOutput("rst_a_rdata", bus.a_rdata, 0);
      checkOutput("rst_b_rdata", bus.b_rdata, 0);
    end
    rst_n = 1'b1;

    // First tie goes to A (write), then B reads the value back.
    serveOne(0);
    checkOutput("first_grant_b", seen_b, 0);
    serveOne(0);
    checkOutput("readback_b", bus.b_rdata, 32'hDEADBEEF);
    checkOutput("readback_a_untouched", bus.a_rdata, 0);

    // Continuous contention: A writes 1 to 10, B reads 10.
    applyStimulus(0, 1'b1, 8'h10, 32'h1);
    applyStimulus(1, 1'b0, 8'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      serveOne(1);
      checkOutput("tie_order", seen_b, i % 2);
      if (i == 1) checkOutput("tie_b_read", bus.b_rdata, 32'h1);
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    idleCycle();

    // Address boundaries.
    applyStimulus(0, 1'b1, 8'h00, 32'hA5A5A5A5);
    serveOne(0);
    applyStimulus(1, 1'b1, 8'hFF, 32'h5A5A5A5A);
    serveOne(0);
    applyStimulus(0, 1'b0, 8'h00, 32'h0);
    serveOne(0);
    applyStimulus(1, 1'b0, 8'hFF, 32'h0);
    serveOne(0);
    checkOutput("bound_00", bus.a_rdata, 32'hA5A5A5A5);
    checkOutput("bound_ff", bus.b_rdata, 32'h5A5A5A5A);

    // Randomised traffic over a small address pool to force reuse.
    for (int it = 0; it < 40; it++) begin
      if (!bus.a_req && $urandom_range(0, 2) != 0)
        applyStimulus(0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], $urandom);
      if (!bus.b_req && $urandom_range(0, 2) != 0)
        applyStimulus(1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], $urandom);
      if (bus.a_req || bus.b_req) serveOne(0);
      else idleCycle();
    end
    for (int d = 0; d < 2; d++) begin
      if (bus.a_req || bus.b_req) serveOne(0);
    end

    // Reset during the strobe of A's write to 20.
    applyStimulus(0, 1'b1, 8'h20, 32'hCAFEF00D);
    tick();
    checkOutput("mid_setup_cs", bus.ram_cs, 1);
    tick();
    checkOutput("mid_strobe_cs", bus.ram_cs, 0);
    rst_n = 1'b0;
    bus.a_req = 1'b0;
    tick();
    // The RAM itself saw a full write strobe on that edge.
    exp_mem[8'h20] = 32'hCAFEF00D;
    exp_rdata_a    = '0;
    exp_rdata_b    = '0;
    model_last_b   = 1'b1;
    last_adrs      = '0;
    checkOutput("mid_rst_cs", bus.ram_cs, 1);
    checkOutput("mid_rst_acks", {bus.a_ack, bus.b_ack}, 0);
    checkOutput("mid_rst_a_rdata", bus.a_rdata, 0);
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 8'h20, 32'h0);
    applyStimulus(1, 1'b0, 8'h10, 32'h0);
    serveOne(0);
    checkOutput("post_rst_grant_b", seen_b, 0);
    serveOne(0);

    // Long strobe instance: single read from A at 5A.
    bus3.a_req = 1'b1; bus3.a_rw = 1'b0; bus3.a_adrs = 8'h5A;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("w3_cs", bus3.ram_cs, (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
      checkOutput("w3_a_ack", bus3.a_ack, (k == 5) ? 32'd1 : 32'd0);
      checkOutput("w3_b_ack", bus3.b_ack, 0);
    end
    checkOutput("w3_a_rdata", bus3.a_rdata, init_mem3[8'h5A]);
    bus3.a_req = 1'b0;
    tick();
    checkOutput("w3_ack_drop", bus3.a_ack, 0);
    checkOutput("w3_rdata_hold", bus3.a_rdata, init_mem3[8'h5A]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
